// File: rtl/tsn_tx_gate.sv
// tsn_tx_gate: holds TX frames until the scheduled window allows a whole frame to start
module tsn_tx_gate #(
  parameter logic [31:0] GUARD_DEFAULT = 32'd12304
) (
  input  logic        mac_axis_aclk,
  input  logic        rst,
  input  logic [63:0] rtc_timer_in,
  input  logic        cfg_enable,
  input  logic [63:0] cfg_base_time,
  input  logic [31:0] cfg_cycle_time,
  input  logic [31:0] cfg_open_offset,
  input  logic [31:0] cfg_open_len,
  input  logic [31:0] cfg_guard_ns,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        gate_open,
  output logic [31:0] hold_cnt
);
  typedef enum logic [1:0] {IDLE, HOLD, PASS} state_t;
  state_t state, state_nx;
  logic en_q, before_q, latch, start_ok, pass, in_win;
  logic [31:0] cyc, off, len, guard, phase_q, phase_nx;
  logic [63:0] cycle_start;
  logic [64:0] next_start;
  logic [32:0] win_end;

  // Schedule arithmetic; the low 32 bits of the phase only need the low 32 bits of each operand
  always_comb begin
    latch = cfg_enable & ~en_q;
    next_start = {1'b0, cycle_start} + {33'd0, cyc};
    phase_nx = rtc_timer_in[31:0] - cycle_start[31:0];
    win_end = {1'b0, off} + {1'b0, len};
    in_win = cfg_enable && rtc_timer_in >= cycle_start && cyc != 32'd0 &&
             phase_nx >= off && {1'b0, phase_nx} < win_end;
    start_ok = !cfg_enable || (!before_q && cyc != 32'd0 && phase_q >= off &&
               {1'b0, phase_q} + {1'b0, guard} <= win_end);
    pass = state == PASS;
    s_axis_tready = pass & m_axis_tready;
    m_axis_tvalid = pass & s_axis_tvalid;
    m_axis_tlast = pass & s_axis_tlast;
    m_axis_tdata = pass ? s_axis_tdata : 8'd0;
  end

  // Snapshot the schedule on each enable rising edge so live cfg changes cannot disturb it
  always_ff @(posedge mac_axis_aclk) begin
    if (rst) begin
      en_q <= 1'b0;
      cyc <= 32'd0;
      off <= 32'd0;
      len <= 32'd0;
      guard <= 32'd0;
    end else begin
      en_q <= cfg_enable;
      if (latch) begin
        cyc <= cfg_cycle_time;
        off <= cfg_open_offset;
        len <= cfg_open_len;
        guard <= cfg_guard_ns == 32'd0 ? GUARD_DEFAULT : cfg_guard_ns;
      end
    end
  end

  // Cycle tracking steps at most one period per clock; phase uses the pre-step cycle_start
  always_ff @(posedge mac_axis_aclk) begin
    if (rst) begin
      cycle_start <= 64'd0;
      phase_q <= 32'd0;
      before_q <= 1'b1;
      gate_open <= 1'b0;
    end else begin
      cycle_start <= latch ? cfg_base_time :
                     (cfg_enable && {1'b0, rtc_timer_in} >= next_start) ? next_start[63:0] : cycle_start;
      phase_q <= phase_nx;
      before_q <= rtc_timer_in < cycle_start;
      gate_open <= in_win;
    end
  end

  // Frame gate state register and wait counter
  always_ff @(posedge mac_axis_aclk) begin
    if (rst) begin
      state <= IDLE;
      hold_cnt <= 32'd0;
    end else begin
      state <= state_nx;
      hold_cnt <= hold_cnt + 32'(state == IDLE && s_axis_tvalid && !start_ok);
    end
  end

  // Gate decision only outside PASS, so an open frame always runs to tlast
  always_comb begin
    state_nx = state;
    state_nx = pass ? ((s_axis_tvalid && m_axis_tready && s_axis_tlast) ? IDLE : PASS) :
               (state == HOLD || s_axis_tvalid) ? (start_ok ? PASS : HOLD) : IDLE;
  end
endmodule

// File: tb/tb_tsn_tx_gate.sv
// tb_tsn_tx_gate: randomized scenarios for the time-aware TX gate against a window-arithmetic model
module tb_tsn_tx_gate;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] rtc = 64'd0;
  logic        cfg_enable = 1'b0;
  logic [63:0] cfg_base_time = 64'd0;
  logic [31:0] cfg_cycle_time = 32'd0, cfg_open_offset = 32'd0, cfg_open_len = 32'd0, cfg_guard_ns = 32'd0;
  logic [7:0]  s_tdata = 8'd0, m_tdata;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic        m_tvalid, m_tlast, m_tready = 1'b1;
  logic        gate_open;
  logic [31:0] hold_cnt;
  logic        rtc_run = 1'b0;
  int          n_chk = 0, n_fail = 0;
  logic [7:0]  sent_q[$], out_q[$];
  logic [63:0] out_rtc[$];
  logic        out_last[$];

  tsn_tx_gate dut (
    .mac_axis_aclk(clk), .rst(rst), .rtc_timer_in(rtc), .cfg_enable(cfg_enable),
    .cfg_base_time(cfg_base_time), .cfg_cycle_time(cfg_cycle_time), .cfg_open_offset(cfg_open_offset),
    .cfg_open_len(cfg_open_len), .cfg_guard_ns(cfg_guard_ns),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .gate_open(gate_open), .hold_cnt(hold_cnt)
  );

  always #5 clk = ~clk;

  // Can a frame start given the time sampled at t? Derived directly from the window definition
  function automatic bit ok_at(input logic [63:0] t);
    longint unsigned ph, g, base, cyc, off, len;
    base = cfg_base_time;
    cyc = 64'(cfg_cycle_time);
    off = 64'(cfg_open_offset);
    len = 64'(cfg_open_len);
    g = cfg_guard_ns == 32'd0 ? 64'd12304 : 64'(cfg_guard_ns);
    if (!cfg_enable) return 1'b1;
    if (cyc == 0 || t < base) return 1'b0;
    ph = (t - base) % cyc;
    return ph >= off && ph + g <= off + len;
  endfunction

  // First beat lands two clocks after the first sampled time that permits a start
  function automatic logic [63:0] exp_beat(input logic [63:0] p);
    logic [63:0] t;
    t = p - 64'd8;
    for (int k = 0; k < 100000; k++) begin
      if (ok_at(t)) return t + 64'd16;
      t = t + 64'd8;
    end
    return '1;
  endfunction

  function automatic bit gate_model(input logic [63:0] t);
    longint unsigned ph;
    if (t < cfg_base_time) return 1'b0;
    ph = (t - cfg_base_time) % 64'(cfg_cycle_time);
    return ph >= 64'(cfg_open_offset) && ph < 64'(cfg_open_offset) + 64'(cfg_open_len);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rtc_run) rtc = rtc + 64'd8;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    cfg_enable = 1'b0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tdata = 8'd0;
    m_tready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic setup(input logic [63:0] base, input logic [31:0] cyc, input logic [31:0] off,
                       input logic [31:0] len, input logic [31:0] grd, input logic [63:0] rtc0);
    reset_dut();
    cfg_base_time = base;
    cfg_cycle_time = cyc;
    cfg_open_offset = off;
    cfg_open_len = len;
    cfg_guard_ns = grd;
    rtc = rtc0;
    rtc_run = 1'b1;
    cfg_enable = 1'b1;
  endtask

  task automatic wait_rtc(input logic [63:0] target);
    for (int c = 0; c < 2000 && rtc < target; c++) tick();
  endtask

  // Drives one frame, recording output beats with the rtc sampled on their transfer edge
  task automatic send_frame(input int n, input bit toggle, output logic [63:0] p);
    int i;
    logic xfer;
    sent_q.delete(); out_q.delete(); out_rtc.delete(); out_last.delete();
    for (int k = 0; k < n; k++) sent_q.push_back(8'($urandom));
    i = 0;
    p = rtc;
    s_tvalid = 1'b1;
    s_tdata = sent_q[0];
    s_tlast = n == 1;
    for (int c = 0; c < 50000 && i < n; c++) begin
      @(negedge clk);
      if (c == 0) p = rtc;
      xfer = s_tready;
      if (m_tvalid && m_tready) begin
        out_q.push_back(m_tdata);
        out_rtc.push_back(rtc);
        out_last.push_back(m_tlast);
      end
      tick();
      if (toggle) m_tready = 1'($urandom_range(0, 1));
      if (xfer) begin
        i++;
        if (i < n) begin
          s_tdata = sent_q[i];
          s_tlast = i == n - 1;
        end
      end
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    m_tready = 1'b1;
    if (i < n) begin
      n_chk++; n_fail++;
      $display("FAIL send_frame timeout: %0d of %0d beats accepted", i, n);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    @(negedge clk);
    n_chk++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL reset s_tready: got %b want 0", s_tready); end
    n_chk++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset m_tvalid: got %b want 0", m_tvalid); end
    n_chk++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL reset m_tlast: got %b want 0", m_tlast); end
    n_chk++; if (m_tdata !== 8'd0) begin n_fail++; $display("FAIL reset m_tdata: got %h want 00", m_tdata); end
    n_chk++; if (gate_open !== 1'b0) begin n_fail++; $display("FAIL reset gate_open: got %b want 0", gate_open); end
    n_chk++; if (hold_cnt !== 32'd0) begin n_fail++; $display("FAIL reset hold_cnt: got %0d want 0", hold_cnt); end
  endtask

  task automatic test_transparent();
    logic [63:0] p;
    reset_dut();
    rtc = 64'd5000;
    rtc_run = 1'b1;
    send_frame(64, 1'b0, p);
    n_chk++; if (out_q.size() !== 64) begin n_fail++; $display("FAIL transparent count: got %0d want 64", out_q.size()); end
    for (int k = 0; k < out_q.size() && k < 64; k++) begin
      n_chk++;
      if (out_q[k] !== sent_q[k]) begin n_fail++; $display("FAIL transparent data[%0d]: got %h want %h", k, out_q[k], sent_q[k]); end
    end
    n_chk++;
    if (out_rtc.size() == 0 || out_rtc[0] !== p + 64'd8) begin
      n_fail++; $display("FAIL transparent first beat: got rtc %0d want %0d", out_rtc.size() ? out_rtc[0] : 64'd0, p + 64'd8);
    end
    n_chk++; if (hold_cnt !== 32'd0) begin n_fail++; $display("FAIL transparent hold_cnt: got %0d want 0", hold_cnt); end
  endtask

  task automatic test_window_hold();
    logic [63:0] p, e;
    setup(64'd1000, 32'd10000, 32'd2000, 32'd3000, 32'd100, 64'd1120);
    wait_rtc(64'd1200);
    send_frame(16, 1'b0, p);
    e = exp_beat(p);
    n_chk++; if (hold_cnt !== 32'd1) begin n_fail++; $display("FAIL hold hold_cnt: got %0d want 1", hold_cnt); end
    n_chk++;
    if (out_rtc.size() == 0 || out_rtc[0] !== e || e !== 64'd3016) begin
      n_fail++; $display("FAIL hold first beat: got rtc %0d want %0d", out_rtc.size() ? out_rtc[0] : 64'd0, e);
    end
    for (int k = 0; k < 16; k++) begin
      n_chk++;
      if (k >= out_q.size() || out_q[k] !== sent_q[k]) begin n_fail++; $display("FAIL hold data[%0d] wrong or missing", k); end
    end
  endtask

  // Follows test_window_hold without a reset so hold_cnt starts nonzero
  task automatic test_reset_mid_frame();
    int i;
    logic xfer;
    n_chk++; if (hold_cnt !== 32'd1) begin n_fail++; $display("FAIL midreset pre hold_cnt: got %0d want 1", hold_cnt); end
    i = 0;
    s_tvalid = 1'b1;
    s_tdata = 8'd0;
    for (int c = 0; c < 500 && i < 20; c++) begin
      @(negedge clk);
      xfer = s_tready;
      tick();
      if (xfer) begin i++; s_tdata = 8'(i); end
    end
    n_chk++; if (i !== 20) begin n_fail++; $display("FAIL midreset progress: got %0d beats want 20", i); end
    rst = 1'b1;
    tick();
    @(negedge clk);
    n_chk++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL midreset m_tvalid: got %b want 0", m_tvalid); end
    n_chk++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL midreset s_tready: got %b want 0", s_tready); end
    n_chk++; if (hold_cnt !== 32'd0) begin n_fail++; $display("FAIL midreset hold_cnt: got %0d want 0", hold_cnt); end
    rst = 1'b0;
    s_tvalid = 1'b0;
  endtask

  task automatic test_guard_band();
    logic [63:0] p, e;
    setup(64'd1000, 32'd10000, 32'd2000, 32'd3000, 32'd100, 64'd5870);
    wait_rtc(64'd5950);
    send_frame(4, 1'b0, p);
    e = exp_beat(p);
    n_chk++; if (hold_cnt !== 32'd1) begin n_fail++; $display("FAIL guard hold_cnt: got %0d want 1", hold_cnt); end
    n_chk++;
    if (out_rtc.size() == 0 || out_rtc[0] !== e || e < 64'd13016) begin
      n_fail++; $display("FAIL guard first beat: got rtc %0d want %0d", out_rtc.size() ? out_rtc[0] : 64'd0, e);
    end
  endtask

  task automatic test_no_truncation();
    logic [63:0] p;
    int lasts;
    setup(64'd1000, 32'd10000, 32'd2000, 32'd3000, 32'd100, 64'd2912);
    wait_rtc(64'd2992);
    send_frame(1500, 1'b1, p);
    n_chk++; if (out_q.size() !== 1500) begin n_fail++; $display("FAIL notrunc count: got %0d want 1500", out_q.size()); end
    for (int k = 0; k < out_q.size() && k < 1500; k++) begin
      n_chk++;
      if (out_q[k] !== sent_q[k]) begin n_fail++; $display("FAIL notrunc data[%0d]: got %h want %h", k, out_q[k], sent_q[k]); end
    end
    lasts = 0;
    foreach (out_last[k]) lasts += int'(out_last[k]);
    n_chk++; if (lasts !== 1) begin n_fail++; $display("FAIL notrunc tlast count: got %0d want 1", lasts); end
    n_chk++;
    if (out_rtc.size() == 0 || out_rtc[0] < 64'd3016 || out_rtc[out_rtc.size() - 1] <= 64'd6000) begin
      n_fail++; $display("FAIL notrunc span: first %0d last %0d", out_rtc.size() ? out_rtc[0] : 64'd0,
                         out_rtc.size() ? out_rtc[out_rtc.size() - 1] : 64'd0);
    end
    s_tvalid = 1'b1;
    @(negedge clk);
    n_chk++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL notrunc idle after tlast: s_tready %b want 0", s_tready); end
    n_chk++;
    if (hold_cnt !== 32'd1) begin n_fail++; $display("FAIL notrunc first hold_cnt: got %0d want 1", hold_cnt); end
    tick();
    @(negedge clk);
    n_chk++;
    if (hold_cnt !== (ok_at(rtc - 64'd16) ? 32'd1 : 32'd2)) begin
      n_fail++; $display("FAIL notrunc second hold_cnt: got %0d want %0d", hold_cnt, ok_at(rtc - 64'd16) ? 1 : 2);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] p1, p2, last1;
    reset_dut();
    rtc = 64'd0;
    rtc_run = 1'b1;
    send_frame(3, 1'b0, p1);
    last1 = out_rtc.size() == 3 ? out_rtc[2] : 64'd0;
    send_frame(3, 1'b0, p2);
    n_chk++;
    if (out_rtc.size() == 0 || out_rtc[0] - last1 !== 64'd16 || out_rtc[0] !== p2 + 64'd8) begin
      n_fail++; $display("FAIL b2b gap: last %0d next %0d want gap 16", last1, out_rtc.size() ? out_rtc[0] : 64'd0);
    end
  endtask

  task automatic test_catch_up();
    setup(64'd0, 32'd10000, 32'd5000, 32'd1000, 32'd100, 64'd95000);
    rtc_run = 1'b0;
    tick();
    repeat (9) tick();
    @(negedge clk);
    n_chk++; if (dut.cycle_start !== 64'd90000) begin n_fail++; $display("FAIL catchup cycle_start: got %0d want 90000", dut.cycle_start); end
    n_chk++; if (gate_open !== 1'b0) begin n_fail++; $display("FAIL catchup gate early: got %b want 0", gate_open); end
    tick();
    @(negedge clk);
    n_chk++; if (gate_open !== 1'b1) begin n_fail++; $display("FAIL catchup gate: got %b want 1", gate_open); end
  endtask

  task automatic test_before_base();
    logic [63:0] prev;
    setup(64'd1000000, 32'd10000, 32'd0, 32'd5000, 32'd100, 64'd999600);
    for (int i = 0; i < 100; i++) begin
      prev = rtc;
      tick();
      @(negedge clk);
      if (i >= 3) begin
        n_chk++;
        if (gate_open !== gate_model(prev)) begin
          n_fail++; $display("FAIL before_base gate at rtc %0d: got %b want %b", prev, gate_open, gate_model(prev));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] p, e, base, rtc0;
    logic [31:0] cyc, off, len, grd;
    bit held;
    int n;
    for (int it = 0; it < 12; it++) begin
      base = 64'($urandom_range(1000, 100000));
      cyc = $urandom_range(15000, 25000);
      off = $urandom_range(16, 1000);
      len = $urandom_range(13000, cyc - off);
      grd = $urandom_range(0, 1) ? 32'd0 : $urandom_range(1, len - 16);
      rtc0 = base - 64'd200 + 64'($urandom_range(0, 2 * cyc));
      setup(base, cyc, off, len, grd, rtc0);
      wait_rtc(rtc0 + 64'd80);
      n = $urandom_range(1, 8);
      held = !ok_at(rtc - 64'd8);
      send_frame(n, 1'b0, p);
      e = exp_beat(p);
      n_chk++;
      if (hold_cnt !== 32'(held)) begin n_fail++; $display("FAIL random[%0d] hold_cnt: got %0d want %0d", it, hold_cnt, held); end
      n_chk++;
      if (out_rtc.size() == 0 || out_rtc[0] !== e) begin
        n_fail++; $display("FAIL random[%0d] first beat: got rtc %0d want %0d", it, out_rtc.size() ? out_rtc[0] : 64'd0, e);
      end
      for (int k = 0; k < n; k++) begin
        n_chk++;
        if (k >= out_q.size() || out_q[k] !== sent_q[k]) begin n_fail++; $display("FAIL random[%0d] data[%0d] wrong or missing", it, k); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_transparent();
    test_window_hold();
    test_reset_mid_frame();
    test_guard_band();
    test_no_truncation();
    test_back_to_back();
    test_catch_up();
    test_before_base();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
